// File: rtl/mat_add_sched.sv
// mat_add_sched: MxN elementwise single-precision matrix adder that sequences one
// shared handshake adder over all elements. Define MAT_ADD_SCHED_SUB_EN for the 'sub' port (Z = A - B).

// Handshake IEEE-754 single adder, round-to-nearest-even, active-high sync reset.
// With the result acked promptly, it transfers 5 cycles after the operand transfer.
module adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  typedef enum logic [2:0] {GET, ALIGN, ADD, NORM, ROUND, PUT} add_state_t;
  add_state_t state, state_n;

  logic [31:0] a, b;
  logic        a_held, b_held, a_keep, b_keep, a_xfer, b_xfer, z_xfer;

  assign a_xfer = input_a_stb & input_a_ack;
  assign b_xfer = input_b_stb & input_b_ack;
  assign z_xfer = output_z_stb & output_z_ack;

  always_comb begin
    state_n = state;
    case (state)
      GET:     if ((a_held | a_xfer) && (b_held | b_xfer)) state_n = ALIGN;
      ALIGN:   state_n = ADD;
      ADD:     state_n = NORM;
      NORM:    state_n = ROUND;
      ROUND:   state_n = PUT;
      PUT:     if (z_xfer) state_n = GET;
      default: state_n = GET;
    endcase
    a_keep = (state == GET) && (state_n == GET) && (a_held | a_xfer);
    b_keep = (state == GET) && (state_n == GET) && (b_held | b_xfer);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= GET;
      a_held       <= 1'b0;
      b_held       <= 1'b0;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z_stb <= 1'b0;
    end else begin
      state        <= state_n;
      a_held       <= a_keep;
      b_held       <= b_keep;
      input_a_ack  <= (state_n == GET) && !a_keep;
      input_b_ack  <= (state_n == GET) && !b_keep;
      output_z_stb <= (state_n == PUT);
    end
  end

  // Unpack and align: mantissas carry guard, round and sticky bits below the LSB.
  logic        sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big, sticky, spec;
  logic [7:0]  ea, eb, xa, xb, d;
  logic [22:0] fa, fb;
  logic [26:0] ma, mb, big_m, sml_m, sml_sh;
  logic [53:0] sh_full;
  logic [31:0] spec_z;

  always_comb begin
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    a_nan  = (ea == 8'hFF) && (|fa);
    b_nan  = (eb == 8'hFF) && (|fb);
    a_inf  = (ea == 8'hFF) && !(|fa);
    b_inf  = (eb == 8'hFF) && !(|fb);
    a_zero = (ea == 8'd0) && !(|fa);
    b_zero = (eb == 8'd0) && !(|fb);
    xa     = (ea == 8'd0) ? 8'd1 : ea;
    xb     = (eb == 8'd0) ? 8'd1 : eb;
    ma     = {ea != 8'd0, fa, 3'b000};
    mb     = {eb != 8'd0, fb, 3'b000};
    a_big  = (xa > xb) || ((xa == xb) && (ma >= mb));
    big_m  = a_big ? ma : mb;
    sml_m  = a_big ? mb : ma;
    d      = a_big ? (xa - xb) : (xb - xa);
    sh_full = {sml_m, 27'd0} >> d;
    if (d > 8'd27) begin
      sml_sh = 27'd0;
      sticky = |sml_m;
    end else begin
      sml_sh = sh_full[53:27];
      sticky = |sh_full[26:0];
    end
    spec   = 1'b1;
    spec_z = 32'h7FC0_0000;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) spec_z = 32'h7FC0_0000;
    else if (a_inf)             spec_z = a;
    else if (b_inf)             spec_z = b;
    else if (a_zero && b_zero)  spec_z = {sa & sb, 31'd0};
    else                        spec   = 1'b0;
  end

  logic [26:0] r_big, r_sml, r_nm;
  logic [27:0] r_sum;
  logic [9:0]  r_exp, r_ne;
  logic        r_sign, r_sub, r_spec;
  logic [31:0] r_spec_z;

  // Normalise; left shifts stop at exponent 1 so tiny results come out subnormal.
  logic [4:0]  lz;
  logic [9:0]  sh, ne;
  logic [26:0] nm;

  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++) if (r_sum[i]) lz = 5'(26 - i);
    sh = 10'd0;
    nm = r_sum[26:0];
    ne = r_exp;
    if (r_sum[27]) begin
      nm = {r_sum[27:2], r_sum[1] | r_sum[0]};
      ne = r_exp + 10'd1;
    end else begin
      sh = ({5'd0, lz} < r_exp) ? {5'd0, lz} : (r_exp - 10'd1);
      nm = r_sum[26:0] << sh;
      ne = r_exp - sh;
    end
  end

  logic        rnd;
  logic [24:0] mant;
  logic [9:0]  ef;
  logic [22:0] fr;
  logic [31:0] res;

  always_comb begin
    rnd  = r_nm[2] & (r_nm[1] | r_nm[0] | r_nm[3]);
    mant = {1'b0, r_nm[26:3]} + {24'd0, rnd};
    ef   = 10'd0;
    fr   = mant[22:0];
    if (mant[24]) begin
      ef = r_ne + 10'd1;
      fr = mant[23:1];
    end else if (mant[23]) begin
      ef = r_ne;
    end
    if (r_spec)               res = r_spec_z;
    else if (r_sum == 28'd0)  res = 32'd0;
    else if (ef >= 10'd255)   res = {r_sign, 8'hFF, 23'd0};
    else                      res = {r_sign, ef[7:0], fr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      output_z <= 32'd0;
    end else begin
      if (a_xfer) a <= input_a;
      if (b_xfer) b <= input_b;
      case (state)
        ALIGN: begin
          r_big    <= big_m;
          r_sml    <= {sml_sh[26:1], sml_sh[0] | sticky};
          r_exp    <= {2'b00, a_big ? xa : xb};
          r_sign   <= a_big ? sa : sb;
          r_sub    <= sa ^ sb;
          r_spec   <= spec;
          r_spec_z <= spec_z;
        end
        ADD:     r_sum <= r_sub ? ({1'b0, r_big} - {1'b0, r_sml}) : ({1'b0, r_big} + {1'b0, r_sml});
        NORM: begin
          r_nm <= nm;
          r_ne <= ne;
        end
        ROUND:   output_z <= res;
        default: ;
      endcase
    end
  end
endmodule

// Controller states:
//   LOAD  | accept A and B independently; leave once both are held
//   ISSUE | offer a_reg[idx], b_reg[idx] to the adder until both are taken
//   WAIT  | take the adder result into z_reg[idx]; next element or PUT
//   PUT   | present z_reg until the consumer acks
module mat_add_sched #(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [M-1:0][N-1:0][31:0] input_a,
  input  logic                    input_a_stb,
  output logic                    input_a_ack,
  input  logic [M-1:0][N-1:0][31:0] input_b,
  input  logic                    input_b_stb,
  output logic                    input_b_ack,
  output logic [M-1:0][N-1:0][31:0] output_z,
  output logic                    output_z_stb,
  input  logic                    output_z_ack
`ifdef MAT_ADD_SCHED_SUB_EN
  ,
  input  logic                    sub
`endif
);
  localparam int E  = M * N;
  localparam int IW = (E > 1) ? $clog2(E) : 1;
  localparam logic [IW-1:0] LAST = IW'(E - 1);

  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, PUT} state_t;
  state_t state, state_n;

  logic [IW-1:0]        idx, idx_n;
  logic [E-1:0][31:0]   a_reg, b_reg, z_reg;
  logic                 a_held, b_held, a_keep, b_keep;
  logic                 add_a_stb, add_b_stb, add_a_ack, add_b_ack;
  logic                 add_z_stb, add_z_ack;
  logic [31:0]          add_a, add_b, add_z;
  logic                 a_xfer, b_xfer, z_xfer, add_a_xfer, add_b_xfer, add_z_xfer;
  logic                 add_a_stb_n, add_b_stb_n;

  assign a_xfer     = input_a_stb & input_a_ack;
  assign b_xfer     = input_b_stb & input_b_ack;
  assign z_xfer     = output_z_stb & output_z_ack;
  assign add_a_xfer = add_a_stb & add_a_ack;
  assign add_b_xfer = add_b_stb & add_b_ack;
  assign add_z_xfer = add_z_stb & add_z_ack;
  assign output_z   = z_reg;
  assign add_a      = a_reg[idx];

`ifdef MAT_ADD_SCHED_SUB_EN
  logic sub_reg;
  assign add_b = b_reg[idx] ^ {sub_reg, 31'd0};
`else
  assign add_b = b_reg[idx];
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      LOAD: if ((a_held | a_xfer) && (b_held | b_xfer)) begin
        state_n = ISSUE;
        idx_n   = '0;
      end
      ISSUE: if ((!add_a_stb || add_a_xfer) && (!add_b_stb || add_b_xfer)) state_n = WAIT;
      WAIT: if (add_z_xfer) begin
        if (idx == LAST) begin
          state_n = PUT;
        end else begin
          state_n = ISSUE;
          idx_n   = idx + IW'(1);
        end
      end
      PUT:     if (z_xfer) state_n = LOAD;
      default: state_n = LOAD;
    endcase
    a_keep = (state == LOAD) && (state_n == LOAD) && (a_held | a_xfer);
    b_keep = (state == LOAD) && (state_n == LOAD) && (b_held | b_xfer);
    // Stbs rise on entry to ISSUE and each falls on its own transfer.
    add_a_stb_n = (state_n == ISSUE) && ((state != ISSUE) || (add_a_stb && !add_a_xfer));
    add_b_stb_n = (state_n == ISSUE) && ((state != ISSUE) || (add_b_stb && !add_b_xfer));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= LOAD;
      idx          <= '0;
      a_held       <= 1'b0;
      b_held       <= 1'b0;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      add_a_stb    <= 1'b0;
      add_b_stb    <= 1'b0;
      add_z_ack    <= 1'b0;
      output_z_stb <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      z_reg        <= '0;
`ifdef MAT_ADD_SCHED_SUB_EN
      sub_reg      <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      a_held       <= a_keep;
      b_held       <= b_keep;
      input_a_ack  <= (state_n == LOAD) && !a_keep;
      input_b_ack  <= (state_n == LOAD) && !b_keep;
      add_a_stb    <= add_a_stb_n;
      add_b_stb    <= add_b_stb_n;
      add_z_ack    <= (state_n == WAIT);
      output_z_stb <= (state_n == PUT);
      if (a_xfer) a_reg <= input_a;
      if (b_xfer) begin
        b_reg <= input_b;
`ifdef MAT_ADD_SCHED_SUB_EN
        sub_reg <= sub;
`endif
      end
      if (add_z_xfer) z_reg[idx] <= add_z;
    end
  end

  adder u_adder (
    .clk          (clk),
    .rst          (~rst),
    .input_a      (add_a),
    .input_a_stb  (add_a_stb),
    .input_a_ack  (add_a_ack),
    .input_b      (add_b),
    .input_b_stb  (add_b_stb),
    .input_b_ack  (add_b_ack),
    .output_z     (add_z),
    .output_z_stb (add_z_stb),
    .output_z_ack (add_z_ack)
  );
endmodule

// File: tb/tb_mat_add_sched.sv
// Bench for mat_add_sched (M=2, N=3): integer-valued operands, so every expected
// element is the exact float of an integer sum computed here.
module tb_mat_add_sched;
  localparam int M = 2;
  localparam int N = 3;
  localparam int E = M * N;
  localparam int ADD_LAT = 5;
  localparam int OP_LAT = E * (ADD_LAT + 1) + 1;

  logic clk = 1'b0;
  logic rst;
  logic [M-1:0][N-1:0][31:0] input_a, input_b, output_z;
  logic input_a_stb, input_b_stb, input_a_ack, input_b_ack;
  logic output_z_stb, output_z_ack;
`ifdef MAT_ADD_SCHED_SUB_EN
  logic sub;
`endif

  mat_add_sched #(.M(M), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
`ifdef MAT_ADD_SCHED_SUB_EN
    ,
    .sub          (sub)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int op_a[E];
  int op_b[E];
  logic [31:0] exp_z[E];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exact single-precision encoding of an integer with magnitude below 2^24.
  function automatic logic [31:0] i2f(input int v);
    int unsigned mag;
    int p;
    logic [31:0] f;
    if (v == 0) return 32'd0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 24; i++) if (mag[i]) p = i;
    f[31]    = (v < 0);
    f[30:23] = 8'(127 + p);
    f[22:0]  = 23'(mag << (23 - p));
    return f;
  endfunction

  task automatic rand_ops();
    for (int k = 0; k < E; k++) begin
      op_a[k] = int'($urandom_range(10000)) - 5000;
      op_b[k] = int'($urandom_range(10000)) - 5000;
    end
  endtask

  task automatic start_op(input bit sb, input int skew_a, input int skew_b);
    int n;
    bit got_a, got_b, ta, tb, held_bad;
    for (int k = 0; k < E; k++) begin
      input_a[k / N][k % N] = i2f(op_a[k]);
      input_b[k / N][k % N] = i2f(op_b[k]);
      exp_z[k] = i2f(sb ? (op_a[k] - op_b[k]) : (op_a[k] + op_b[k]));
    end
`ifdef MAT_ADD_SCHED_SUB_EN
    sub = sb;
`endif
    chk("idle_acks", {30'd0, input_a_ack, input_b_ack}, 32'd3);
    n = 0; got_a = 0; got_b = 0; held_bad = 0;
    while (!(got_a && got_b) && n < 200) begin
      if (!got_a && n >= skew_a) input_a_stb = 1'b1;
      if (!got_b && n >= skew_b) input_b_stb = 1'b1;
      ta = input_a_stb && input_a_ack;
      tb = input_b_stb && input_b_ack;
      tick();
      n++;
      if (ta) begin got_a = 1; input_a_stb = 1'b0; end
      if (tb) begin got_b = 1; input_b_stb = 1'b0; end
      if ((got_a && input_a_ack) || (got_b && input_b_ack)) held_bad = 1;
    end
    chk("captured", {30'd0, got_a, got_b}, 32'd3);
    chk("ack_low_after_capture", {31'd0, held_bad}, 32'd0);
  endtask

  task automatic finish_op(input int bp);
    int lat;
    bit busy_bad, stable_bad;
    logic [M-1:0][N-1:0][31:0] held;
    // Offer junk while busy: acks must stay low so nothing is captured.
    input_a_stb = 1'b1;
    input_a[0][0] = ~input_a[0][0];
    lat = 1; busy_bad = 0;
    while (!output_z_stb && lat < 1000) begin
      if (input_a_ack || input_b_ack) busy_bad = 1;
      tick();
      lat++;
    end
    input_a_stb = 1'b0;
    chk("latency", lat, OP_LAT);
    chk("busy_acks_low", {31'd0, busy_bad}, 32'd0);
    for (int k = 0; k < E; k++) chk($sformatf("z[%0d]", k), output_z[k / N][k % N], exp_z[k]);
    held = output_z;
    stable_bad = 0;
    for (int c = 0; c < bp; c++) begin
      tick();
      if (output_z !== held || !output_z_stb || input_a_ack || input_b_ack) stable_bad = 1;
    end
    chk("backpressure_stable", {31'd0, stable_bad}, 32'd0);
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    chk("z_stb_drop", {31'd0, output_z_stb}, 32'd0);
    chk("acks_after_put", {30'd0, input_a_ack, input_b_ack}, 32'd3);
  endtask

  task automatic run_op(input bit sb, input int skew_a, input int skew_b, input int bp);
    start_op(sb, skew_a, skew_b);
    finish_op(bp);
  endtask

  initial begin
    bit seen;
    rst = 1'b0;
    input_a_stb = 1'b1;
    input_b_stb = 1'b1;
    output_z_ack = 1'b0;
    input_a = '1;
    input_b = '1;
`ifdef MAT_ADD_SCHED_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_acks", {30'd0, input_a_ack, input_b_ack}, 32'd0);
    chk("rst_z_stb", {31'd0, output_z_stb}, 32'd0);
    for (int k = 0; k < E; k++) chk("rst_z", output_z[k / N][k % N], 32'd0);
    input_a_stb = 1'b0;
    input_b_stb = 1'b0;
    rst = 1'b1;
    chk("release_c0_acks", {30'd0, input_a_ack, input_b_ack}, 32'd0);
    tick();
    chk("release_c1_acks", {30'd0, input_a_ack, input_b_ack}, 32'd3);

    for (int k = 0; k < E; k++) begin op_a[k] = 1; op_b[k] = 2; end
    run_op(0, 0, 0, 0);
    chk("basic_literal", output_z[1][2], 32'h4040_0000);

    rand_ops();
    run_op(0, 0, 5, 10);

    for (int k = 0; k < E; k++) begin op_a[k] = k; op_b[k] = 0; end
    run_op(0, 0, 0, 2);

    for (int r = 0; r < 4; r++) begin
      rand_ops();
      run_op(0, int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(4)));
    end

    // Reset lands in WAIT of element 2 (element k waits at capture+2+6k .. +6+6k).
    rand_ops();
    start_op(0, 0, 0);
    repeat (14) tick();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    seen = 0;
    repeat (60) begin
      tick();
      if (output_z_stb) seen = 1;
    end
    chk("midrst_no_output", {31'd0, seen}, 32'd0);
    rand_ops();
    run_op(0, 1, 0, 1);

`ifdef MAT_ADD_SCHED_SUB_EN
    for (int k = 0; k < E; k++) begin op_a[k] = 3; op_b[k] = 1; end
    run_op(1, 0, 0, 0);
    chk("sub_literal", output_z[0][1], 32'h4000_0000);
    run_op(0, 0, 2, 0);
    chk("add_literal", output_z[1][0], 32'h4080_0000);
    rand_ops();
    run_op(1, 2, 0, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end
endmodule
